// File: rtl/arq_flow_ctrl_multi.sv
// Per-LT ARQ / flow controller: tracks SEQN, ARQN, outstanding state, retransmit count and FLOW stop.
// TX action and all pulses are registered: they appear 1 clk after the triggering input pulse.
// No backpressure: every in-range tx_start_p yields its own action pulse, so back-to-back starts are allowed.
module arq_flow_ctrl_multi #(
  parameter int NUM_LT   = 8,
  parameter int LTW      = 3,
  parameter int RETX_MAX = 0,
  parameter int CNTW     = 4
) (
  input  logic              clk_6M,
  input  logic              rst,
  input  logic              conn_new_p,
  input  logic [LTW-1:0]    conn_lt,
  input  logic              tx_start_p,
  input  logic [LTW-1:0]    tx_lt,
  input  logic              tx_is_data,
  input  logic              rx_hdr_p,
  input  logic [LTW-1:0]    rx_lt,
  input  logic              rx_hecgood,
  input  logic              rx_arqn,
  input  logic              rx_flow,
  input  logic              rx_seqn,
  input  logic              rx_is_data,
  input  logic              rx_py_end_p,
  input  logic              rx_crcgood,
  input  logic              flush_req_p,
  input  logic [LTW-1:0]    flush_lt,
  output logic [1:0]        tx_action,
  output logic              tx_action_vld,
  output logic [NUM_LT-1:0] tx_seqn,
  output logic [NUM_LT-1:0] tx_arqn,
  output logic [NUM_LT-1:0] remote_stop,
  output logic              rx_accept_p,
  output logic              flush_done_p
);

  localparam int              IDXW     = (NUM_LT > 1) ? $clog2(NUM_LT) : 1;
  localparam logic [LTW:0]    LT_LIMIT = (LTW+1)'(NUM_LT);
  localparam logic [CNTW-1:0] RETX_LIM = CNTW'(RETX_MAX);
  localparam logic [CNTW-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    ACT_NEW   = 2'd0,
    ACT_RETX  = 2'd1,
    ACT_FLUSH = 2'd2,
    ACT_HOLD  = 2'd3
  } act_e;

  // Per-LT state
  logic [NUM_LT-1:0]           seqn_q, seqn_d;
  logic [NUM_LT-1:0]           old_q, old_d;
  logic [NUM_LT-1:0]           arqn_q, arqn_d;
  logic [NUM_LT-1:0]           stop_q, stop_d;
  logic [NUM_LT-1:0]           outst_q, outst_d;
  logic [NUM_LT-1:0]           fpend_q, fpend_d;
  logic [NUM_LT-1:0][CNTW-1:0] cnt_q, cnt_d;

  // Last good RX header, consumed at payload end
  logic                        hdr_vld_q, hdr_vld_d;
  logic [IDXW-1:0]             hdr_lt_q, hdr_lt_d;
  logic                        hdr_seqn_q, hdr_seqn_d;
  logic                        hdr_data_q, hdr_data_d;

  // Registered outputs
  act_e                        act_q, act_d;
  logic                        act_vld_q, act_vld_d;
  logic                        accept_q, accept_d;
  logic                        fdone_q, fdone_d;

  // Range checks; out-of-range LT addresses are dropped
  logic                        rx_ok, tx_ok, fl_ok, cn_ok;
  logic [IDXW-1:0]             rx_idx, tx_idx, fl_idx, cn_idx;
  logic                        flush_take;

  assign rx_ok  = ({1'b0, rx_lt}    < LT_LIMIT);
  assign tx_ok  = ({1'b0, tx_lt}    < LT_LIMIT);
  assign fl_ok  = ({1'b0, flush_lt} < LT_LIMIT);
  assign cn_ok  = ({1'b0, conn_lt}  < LT_LIMIT);
  assign rx_idx = rx_lt[IDXW-1:0];
  assign tx_idx = tx_lt[IDXW-1:0];
  assign fl_idx = flush_lt[IDXW-1:0];
  assign cn_idx = conn_lt[IDXW-1:0];

  // Next state: RX header, RX payload, TX decision, flush request, then connection reset (highest priority)
  always_comb begin
    seqn_d     = seqn_q;
    old_d      = old_q;
    arqn_d     = arqn_q;
    stop_d     = stop_q;
    outst_d    = outst_q;
    fpend_d    = fpend_q;
    cnt_d      = cnt_q;
    hdr_vld_d  = hdr_vld_q;
    hdr_lt_d   = hdr_lt_q;
    hdr_seqn_d = hdr_seqn_q;
    hdr_data_d = hdr_data_q;
    act_d      = act_q;
    act_vld_d  = 1'b0;
    accept_d   = 1'b0;
    fdone_d    = 1'b0;
    flush_take = 1'b0;

    // Good header: FLOW and ack take effect now so a same-cycle TX decision sees them
    if (rx_hdr_p && rx_hecgood) begin
      hdr_vld_d  = rx_ok;
      hdr_lt_d   = rx_idx;
      hdr_seqn_d = rx_seqn;
      hdr_data_d = rx_is_data;
      if (rx_ok) begin
        stop_d[rx_idx] = ~rx_flow;
        if (rx_arqn) begin
          outst_d[rx_idx] = 1'b0;
          cnt_d[rx_idx]   = '0;
          fpend_d[rx_idx] = 1'b0;
        end
      end
    end

    // Payload end judges the previously latched header
    if (rx_py_end_p && hdr_vld_q && hdr_data_q) begin
      if (hdr_seqn_q == old_q[hdr_lt_q]) begin
        arqn_d[hdr_lt_q] = 1'b1;
      end else if (rx_crcgood) begin
        arqn_d[hdr_lt_q] = 1'b1;
        old_d[hdr_lt_q]  = hdr_seqn_q;
        accept_d         = 1'b1;
      end else begin
        arqn_d[hdr_lt_q] = 1'b0;
      end
    end

    // A flush only makes sense while something is unacknowledged
    flush_take = flush_req_p && fl_ok && outst_d[fl_idx];

    if (tx_start_p && tx_ok) begin
      act_vld_d = 1'b1;
      if (tx_is_data && stop_d[tx_idx]) begin
        act_d = ACT_HOLD;
      end else if (!tx_is_data) begin
        act_d = ACT_NEW;
      end else if (!outst_d[tx_idx]) begin
        act_d           = ACT_NEW;
        seqn_d[tx_idx]  = ~seqn_q[tx_idx];
        outst_d[tx_idx] = 1'b1;
      end else if (fpend_d[tx_idx] || ((RETX_MAX != 0) && (cnt_d[tx_idx] == RETX_LIM))) begin
        act_d           = ACT_FLUSH;
        seqn_d[tx_idx]  = ~seqn_q[tx_idx];
        cnt_d[tx_idx]   = '0;
        fpend_d[tx_idx] = 1'b0;
        fdone_d         = 1'b1;
      end else begin
        act_d = ACT_RETX;
        if (cnt_d[tx_idx] != CNT_SAT) begin
          cnt_d[tx_idx] = cnt_d[tx_idx] + 1'b1;
        end
      end
    end

    // Set after the TX decision so a same-cycle request survives into the next start
    if (flush_take) begin
      fpend_d[fl_idx] = 1'b1;
    end

    if (conn_new_p && cn_ok) begin
      seqn_d[cn_idx]  = 1'b1;
      old_d[cn_idx]   = 1'b0;
      arqn_d[cn_idx]  = 1'b0;
      stop_d[cn_idx]  = 1'b0;
      outst_d[cn_idx] = 1'b0;
      cnt_d[cn_idx]   = '0;
      fpend_d[cn_idx] = 1'b0;
      if (hdr_lt_q == cn_idx) begin
        accept_d = 1'b0;
      end
      if (tx_ok && (tx_idx == cn_idx)) begin
        fdone_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      seqn_q     <= '1;
      old_q      <= '0;
      arqn_q     <= '0;
      stop_q     <= '0;
      outst_q    <= '0;
      fpend_q    <= '0;
      cnt_q      <= '0;
      hdr_vld_q  <= 1'b0;
      hdr_lt_q   <= '0;
      hdr_seqn_q <= 1'b0;
      hdr_data_q <= 1'b0;
      act_q      <= ACT_NEW;
      act_vld_q  <= 1'b0;
      accept_q   <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      seqn_q     <= seqn_d;
      old_q      <= old_d;
      arqn_q     <= arqn_d;
      stop_q     <= stop_d;
      outst_q    <= outst_d;
      fpend_q    <= fpend_d;
      cnt_q      <= cnt_d;
      hdr_vld_q  <= hdr_vld_d;
      hdr_lt_q   <= hdr_lt_d;
      hdr_seqn_q <= hdr_seqn_d;
      hdr_data_q <= hdr_data_d;
      act_q      <= act_d;
      act_vld_q  <= act_vld_d;
      accept_q   <= accept_d;
      fdone_q    <= fdone_d;
    end
  end

  assign tx_action     = act_q;
  assign tx_action_vld = act_vld_q;
  assign tx_seqn       = seqn_q;
  assign tx_arqn       = arqn_q;
  assign remote_stop   = stop_q;
  assign rx_accept_p   = accept_q;
  assign flush_done_p  = fdone_q;

endmodule
